// File: rtl/status_pkg.sv
// Shared types and helpers for the digit-serial subtract/status detector.
package status_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Digit counter width; a single-digit configuration still needs one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_status_detector_sub_digit.sv
// One DIGIT-bit slice of the serial subtractor: d = a - b - bin, with borrow out.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] full_s;

  // The extra top bit of the widened difference is the borrow out.
  assign full_s = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  assign d      = full_s[DIGIT-1:0];
  assign bout   = full_s[DIGIT];

endmodule

// File: rtl/serial_status_detector.sv
// Digit-serial in1 - in2 with start/busy/done handshake and borrow/eq/slt/ovf flags.
module serial_status_detector
  import status_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             bout,
  output logic             eq,
  output logic             slt,
  output logic             ovf,
  output logic [WIDTH-1:0] diff
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [CW-1:0]    cnt_r;
  logic             borrow_r;
  logic             nz_r;

  logic [DIGIT-1:0] d_s;
  logic             bo_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;
  logic             ovf_s;

  sub_digit #(.DIGIT(DIGIT)) u_sub (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bo_s)
  );

  // Result assembles from the top down, so after NDIG digits digit j sits at position j.
  always_comb begin
    res_next_s = WIDTH'({d_s, res_r} >> DIGIT);
    last_s     = (cnt_r == CW'(NDIG - 1));
    ovf_s      = (a_msb_r != b_msb_r) && (res_next_s[WIDTH-1] != a_msb_r);
  end

  // Control FSM, operand/result shift registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      borrow_r <= 1'b0;
      nz_r     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bout     <= 1'b0;
      eq       <= 1'b0;
      slt      <= 1'b0;
      ovf      <= 1'b0;
      diff     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r      <= in1;
            b_r      <= in2;
            a_msb_r  <= in1[WIDTH-1];
            b_msb_r  <= in2[WIDTH-1];
            cnt_r    <= {CW{1'b0}};
            borrow_r <= 1'b0;
            nz_r     <= 1'b0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          a_r      <= a_r >> DIGIT;
          b_r      <= b_r >> DIGIT;
          res_r    <= res_next_s;
          borrow_r <= bo_s;
          nz_r     <= nz_r | (|d_s);
          if (last_s) begin
            bout    <= bo_s;
            eq      <= ~(nz_r | (|d_s));
            diff    <= res_next_s;
            ovf     <= ovf_s;
            slt     <= res_next_s[WIDTH-1] ^ ovf_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
